// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-indexed data memory with
// asynchronous read and synchronous write; sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_rd_i
);
    typedef enum logic {IDLE, MERGE} state_t;

    state_t      state_q, state_d;
    logic [29:0] widx_q;
    logic [1:0]  lane_q;
    logic        half_q;
    logic [15:0] wdata_q;
    logic [31:0] merge_q;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        accept;
    logic        err;
    logic        is_rmw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged_wd;

    assign accept = req_valid_i && (state_q == IDLE);
    assign is_rmw = req_we_i && (req_size_i != 2'b10);

    always_comb begin
        err = 1'b0;
        if (req_size_i == 2'b11)                           err = 1'b1;
        if (req_size_i == 2'b01 && req_addr_i[0])          err = 1'b1;
        if (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00) err = 1'b1;
        if ({2'b00, req_addr_i[31:2]} >= 32'(MEM_WORDS))   err = 1'b1;
    end

    assign byte_sel = mem_rd_i[{req_addr_i[1:0], 3'b000} +: 8];
    assign half_sel = req_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

    always_comb begin
        case (req_size_i)
            2'b00:   load_ext = req_unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = req_unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_ext = mem_rd_i;
        endcase
    end

    // Each byte lane of the write-back word either keeps the captured memory
    // byte or takes the matching byte of the store data.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic hit;
            assign hit = half_q ? (lane_q[1] == 1'(gi / 2)) : (lane_q == 2'(gi));
            assign merged_wd[8*gi +: 8] = !hit   ? merge_q[8*gi +: 8] :
                                          half_q ? wdata_q[8*(gi % 2) +: 8] :
                                                   wdata_q[7:0];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        mem_we_o     = 1'b0;
        mem_wd_o     = req_wdata_i;
        mem_addr_o   = {2'b00, req_addr_i[31:2]};
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_we_i) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_ext;
                    end else if (!is_rmw) begin
                        mem_we_o     = 1'b1;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = MERGE;
                    end
                end
            end
            MERGE: begin
                mem_addr_o   = {2'b00, widx_q};
                mem_wd_o     = merged_wd;
                mem_we_o     = 1'b1;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            widx_q       <= '0;
            lane_q       <= '0;
            half_q       <= 1'b0;
            wdata_q      <= '0;
            merge_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            if (accept) begin
                widx_q  <= req_addr_i[31:2];
                lane_q  <= req_addr_i[1:0];
                half_q  <= req_size_i[0];
                wdata_q <= req_wdata_i[15:0];
                merge_q <= mem_rd_i;
            end
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, multi-cycle corner cases,
// and random requests checked against a byte-level reference memory.
module tb_load_store_unit;
    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;
    logic        mem_we;
    logic        mem_clr;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    int cmp_n  = 0;
    int fail_n = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_we_o(mem_we), .mem_rd_i(mem_rd)
    );

    // Attached data memory: asynchronous read, synchronous write.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'h0;
        end else if (mem_we && mem_addr < MEM_WORDS) begin
            mem[mem_addr[5:0]] <= mem_wd;
        end
    end
    assign mem_rd = (mem_addr < MEM_WORDS) ? mem[mem_addr[5:0]] : 32'h0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-granular view of memory; also advances ref_mem for stores.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
        int nb, wi, off;
        logic [31:0] v, mask, w;
        nb = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        err = (size == 3) || (addr % nb != 0) || ((addr / 4) >= MEM_WORDS);
        rdata = 32'h0;
        lat = 1;
        if (!err) begin
            wi  = int'(addr / 4);
            off = int'(addr % 4);
            if (!we) begin
                v    = ref_mem[wi] >> (8 * off);
                mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
                v    = v & mask;
                if (!uns && v[8*nb-1]) v = v | ~mask;
                rdata = v;
            end else begin
                w = ref_mem[wi];
                for (int i = 0; i < nb; i++) begin
                    w = (w & ~(32'hFF << (8 * (off + i)))) |
                        (((wdata >> (8 * i)) & 32'hFF) << (8 * (off + i)));
                end
                ref_mem[wi] = w;
                lat = (nb < 4) ? 2 : 1;
            end
        end
    endtask

    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int we_cnt, busy_cnt, lat;
        logic got;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        #1;
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        check({tag, " idle_resp"}, 32'(resp_valid), 32'd0);
        check({tag, " mem_addr"}, mem_addr, {2'b00, addr[31:2]});
        we_cnt = int'(mem_we);
        busy_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        lat = 1;
        got = 1'b0;
        while (!got && lat <= 8) begin
            we_cnt += int'(mem_we);
            if (!req_ready) busy_cnt++;
            if (resp_valid) got = 1'b1;
            else begin
                @(negedge clk); #1;
                lat++;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        check({tag, " err"}, 32'(resp_err), 32'(exp_err));
        check({tag, " we_cycles"}, 32'(we_cnt), (we && !exp_err) ? 32'd1 : 32'd0);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        $display("txn %s we=%0d size=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 tag, we, size, addr, wdata, resp_rdata, resp_err, lat);
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    initial begin
        logic [31:0] m_rdata;
        logic        m_err;
        int          m_lat;
        logic        r_we, r_uns;
        logic [1:0]  r_size;
        logic [31:0] r_addr, r_wdata;
        int          r;

        rst_n = 1'b0; mem_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; mem_clr = 1'b0;
        #1;
        check("reset ready", 32'(req_ready), 32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset rdata", resp_rdata, 32'h0);
        check("reset err", 32'(resp_err), 32'd0);

        //              we    size   uns   addr         wdata         exp_rdata     err  lat
        tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1));
        tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1));
        tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 32'h0,        1'b0, 1));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 1));
        tbl.push_back(mk(1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0, 1));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        32'hFFFFFFFF, 1'b0, 1));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'h00007F01, 1'b0, 1));
        tbl.push_back(mk(1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h000080FF, 1'b0, 1));
        tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0,        1'b0, 1));
        tbl.push_back(mk(1'b1, 2'b00, 1'b1, 32'h11, 32'h123456AA, 32'h0,        1'b0, 2));
        tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h1122AA44, 1'b0, 1));
        tbl.push_back(mk(1'b1, 2'b01, 1'b0, 32'h12, 32'h9999BEEF, 32'h0,        1'b0, 2));
        tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hBEEFAA44, 1'b0, 1));
        tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h12, 32'h0,        32'h0,        1'b1, 1));
        tbl.push_back(mk(1'b1, 2'b01, 1'b0, 32'h11, 32'h5555,     32'h0,        1'b1, 1));
        tbl.push_back(mk(1'b1, 2'b11, 1'b0, 32'h10, 32'h77777777, 32'h0,        1'b1, 1));
        tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D, 32'h0,       1'b1, 1));
        tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hBEEFAA44, 1'b0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, m_rdata, m_err, m_lat);
            run_req($sformatf("vec%0d", i), tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr,
                    tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_lat);
        end
        check("errors left word4", mem[4], 32'hBEEFAA44);

        // Back-to-back loads: one response per cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h10;
        #1;
        check("b2b first valid", 32'(resp_valid), 32'd1);
        check("b2b first rdata", resp_rdata, 32'hBEEFAA44);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("b2b second valid", 32'(resp_valid), 32'd1);
        check("b2b second rdata", resp_rdata, 32'h00000044);
        @(negedge clk); #1;
        check("b2b pulse end", 32'(resp_valid), 32'd0);
        $display("txn b2b loads @0x10 done");

        // Reset asserted while the merged write is pending.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("rmw_rst merge we", 32'(mem_we), 32'd1);
        check("rmw_rst merge ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rmw_rst we dropped", 32'(mem_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("rmw_rst no resp", 32'(resp_valid), 32'd0);
            check("rmw_rst ready", 32'(req_ready), 32'd1);
            @(negedge clk);
        end
        check("rmw_rst word kept", mem[4], 32'hBEEFAA44);
        $display("txn reset during merge done");

        for (int n = 0; n < 300; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r      = int'($urandom_range(0, 7));
            r_size = (r == 7) ? 2'b11 : 2'(r % 3);
            r_uns  = 1'($urandom_range(0, 1));
            r_addr = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, MEM_WORDS * 4 + 7);
            r_wdata = $urandom;
            model(r_we, r_size, r_uns, r_addr, r_wdata, m_rdata, m_err, m_lat);
            run_req($sformatf("rnd%0d", n), r_we, r_size, r_uns, r_addr, r_wdata, m_rdata, m_err, m_lat);
        end

        for (int i = 0; i < MEM_WORDS; i++) check($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end
endmodule
